sd_spi_byte: RTL and testbench
==============================

# sd_spi_byte

Byte-level SPI master for the SD-card interface, sitting directly upstream of the SD DMA controller. It serves the DMA side's `sd_start`/`sd_rdy`/`sd_recvdata` handshake by shifting out 0xFF and capturing one received byte. It also exposes a small CPU register window through `ports.v` for command bytes, chip-select and speed control. SPI mode 0, MSB first, SCK rate set by a clock divider.

## Interface
- `SLOW_DIV`, default 8'd59: half-period divider in slow (init) mode; SCK half-period = `SLOW_DIV`+1 clk cycles.
- `FAST_DIV`, default 8'd0: half-period divider in fast mode.
- `clk` in 1: system clock; only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sd_start` in 1: DMA-side request; one-cycle pulse starts a transfer sending 0xFF.
- `sd_rdy` out 1: level; 1 = idle and `sd_recvdata` valid.
- `sd_recvdata` out 8: last received byte, held until next transfer completes.
- `din` in 8: CPU write data from `ports.v`.
- `dout` out 8: CPU read data, combinational on `regsel`.
- `module_select` in 1: block selected by `ports.v`.
- `write_strobe` in 1: one-cycle write strobe.
- `regsel` in 2: 00 data, 01 control, 10 status, 11 reserved.
- `sd_clk` out 1: SPI SCK.
- `sd_do` out 1: SPI MOSI.
- `sd_di` in 1: SPI MISO.
- `sd_cs_n` out 1: card chip select, active-low.

## Operation
- Start sources: `sd_start`=1 (tx byte 0xFF), or CPU write to data reg (tx byte = `din`). Accepted only when `sd_rdy`=1; ignored while busy (no queuing).
- Simultaneous `sd_start` and CPU data write in the same idle cycle: `sd_start` wins; the CPU write is discarded.
- Divider latched at acceptance: `FAST_DIV` if control bit1=0, else `SLOW_DIV`. Control writes during a transfer affect only the next byte.
- Control reg (regsel 01), write: bit0 → `sd_cs_n`, applied next clk edge even mid-transfer; bit1 → slow mode. Read: {6'b0, slow, cs_n}.
- Data reg (regsel 00) read returns `sd_recvdata`. Status (regsel 10) read: {~sd_rdy, 7'b0}. Reserved read returns 8'hFF.
- States: IDLE, SHIFT (16 half-periods), back to IDLE. Half-period counter reloads with the latched divider; a 4-bit half-period index counts 0..15.
- Mode 0: `sd_do` holds tx bit 7 from acceptance and changes on each SCK falling edge; `sd_di` is sampled into the rx shifter at the clk edge where `sd_clk` goes 0→1; MSB first.
- On completion, the rx shifter is copied to `sd_recvdata`, `sd_rdy`=1, `sd_clk`=0, and `sd_do`=1.

## Timing
- Reset values: `sd_rdy`=1, `sd_recvdata`=8'hFF, `sd_clk`=0, `sd_do`=1, `sd_cs_n`=1, slow=1, state IDLE.
- `sd_rdy` goes 0 at the same clk edge that samples the start. In the following cycle, a waiting FSM must see `sd_rdy`=0.
- Busy duration: exactly 16·(DIV+1) clk cycles with `sd_rdy`=0. With DIV=0, `sd_clk` toggles every cycle.
- `sd_rdy` and the new `sd_recvdata` update at the same edge. A consumer sampling on `sd_rdy`=1 sees the fresh byte.
- Back-to-back: a new start is accepted in the first cycle `sd_rdy`=1; there are no dead cycles beyond that.
- Reset mid-transfer aborts immediately to reset values. The partial byte is discarded.

## Test plan
- Fast mode (write control 8'h00), pulse `sd_start`, drive MISO 0xA5 → `sd_rdy` low 16 cycles; `sd_recvdata`=8'hA5; MOSI 1 on all 8 bits; 8 SCK rising edges.
- CPU write 8'h40 to data reg, MISO held 1 → MOSI bits 0,1,0,0,0,0,0,0; `sd_recvdata`=8'hFF; status read 8'h80 while busy, 8'h00 after.
- Slow mode after reset, `sd_start` → `sd_rdy` low exactly 960 cycles; SCK half-period 60 cycles.
- `sd_start` pulse and CPU data write of 8'h00 in the same idle cycle → MOSI sends 0xFF. Second `sd_start` mid-transfer is ignored, and busy length is unchanged.
- Write control 8'h01 mid-transfer → `sd_cs_n`=1 next cycle; transfer completes normally. Write 8'h02 mid-transfer → current byte stays fast, next byte slow.
- Assert `rst_n`=0 at bit 4 of a transfer → all outputs return to reset values asynchronously; after release, a new `sd_start` completes normally.

Source files
------------

// File: rtl/sd_spi_byte.sv
// Byte-level SPI master (mode 0, MSB first) serving the SD DMA handshake and a
// small CPU register window for command bytes, chip-select and speed control.
module sd_spi_byte #(
    parameter logic [7:0] SLOW_DIV = 8'd59,
    parameter logic [7:0] FAST_DIV = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sd_start,
    output logic       sd_rdy,
    output logic [7:0] sd_recvdata,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       module_select,
    input  logic       write_strobe,
    input  logic [1:0] regsel,
    output logic       sd_clk,
    output logic       sd_do,
    input  logic       sd_di,
    output logic       sd_cs_n
);

    typedef enum logic {StIdle, StShift} state_e;

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  recv_q, recv_d;
    logic        sck_q, sck_d;
    logic        do_q, do_d;
    logic        cs_n_q, cs_n_d;
    logic        slow_q, slow_d;
    logic        ctrl_wr, data_wr;
    logic [7:0]  tx_sel, div_sel;

    assign ctrl_wr = module_select & write_strobe & (regsel == 2'b01);
    assign data_wr = module_select & write_strobe & (regsel == 2'b00);

    // State register; reset aborts any transfer and discards the partial byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= 8'd0;
            cnt_q   <= 8'd0;
            idx_q   <= 4'd0;
            tx_q    <= 8'hFF;
            rx_q    <= 8'hFF;
            recv_q  <= 8'hFF;
            sck_q   <= 1'b0;
            do_q    <= 1'b1;
            cs_n_q  <= 1'b1;
            slow_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            recv_q  <= recv_d;
            sck_q   <= sck_d;
            do_q    <= do_d;
            cs_n_q  <= cs_n_d;
            slow_q  <= slow_d;
        end
    end

    // Next-state: accept a start when idle, then walk 16 SCK half-periods
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        recv_d  = recv_q;
        sck_d   = sck_q;
        do_d    = do_q;
        cs_n_d  = cs_n_q;
        slow_d  = slow_q;
        // DMA request has priority over a CPU data write in the same cycle
        tx_sel  = sd_start ? 8'hFF : din;
        div_sel = slow_q ? SLOW_DIV : FAST_DIV;

        // Control writes land immediately, even mid-transfer; speed only
        // takes effect at the next acceptance because div is latched then.
        if (ctrl_wr) begin
            cs_n_d = din[0];
            slow_d = din[1];
        end

        unique case (state_q)
            StIdle: begin
                if (sd_start || data_wr) begin
                    state_d = StShift;
                    tx_d    = tx_sel;
                    div_d   = div_sel;
                    cnt_d   = div_sel;
                    idx_d   = 4'd0;
                    sck_d   = 1'b0;
                    do_d    = tx_sel[7];
                end
            end
            StShift: begin
                if (cnt_q == 8'd0) begin
                    cnt_d = div_q;
                    idx_d = idx_q + 4'd1;
                    if (!idx_q[0]) begin
                        // Rising SCK edge: sample MISO
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], sd_di};
                    end else begin
                        // Falling SCK edge: present next MOSI bit
                        sck_d = 1'b0;
                        tx_d  = {tx_q[6:0], 1'b0};
                        do_d  = tx_q[6];
                        if (idx_q == 4'd15) begin
                            state_d = StIdle;
                            recv_d  = rx_q;
                            do_d    = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    assign sd_rdy      = (state_q == StIdle);
    assign sd_recvdata = recv_q;
    assign sd_clk      = sck_q;
    assign sd_do       = do_q;
    assign sd_cs_n     = cs_n_q;

    // CPU read mux
    always_comb begin
        dout = 8'hFF;
        unique case (regsel)
            2'b00: dout = recv_q;
            2'b01: dout = {6'b0, slow_q, cs_n_q};
            2'b10: dout = {~sd_rdy, 7'b0};
            2'b11: dout = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_sd_spi_byte.sv
// Scoreboard bench for sd_spi_byte: stimulus pushes expected transfers, a
// negedge monitor reconstructs each transfer from the SPI pins and compares.
module tb_sd_spi_byte;

    logic       clk;
    logic       rst_n;
    logic       sd_start;
    logic       sd_rdy;
    logic [7:0] sd_recvdata;
    logic [7:0] din;
    logic [7:0] dout;
    logic       module_select;
    logic       write_strobe;
    logic [1:0] regsel;
    logic       sd_clk;
    logic       sd_do;
    logic       sd_di;
    logic       sd_cs_n;

    sd_spi_byte dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sd_start     (sd_start),
        .sd_rdy       (sd_rdy),
        .sd_recvdata  (sd_recvdata),
        .din          (din),
        .dout         (dout),
        .module_select(module_select),
        .write_strobe (write_strobe),
        .regsel       (regsel),
        .sd_clk       (sd_clk),
        .sd_do        (sd_do),
        .sd_di        (sd_di),
        .sd_cs_n      (sd_cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         len;
        int         half;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] pat = 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MISO driver: present the next pattern bit after each SCK rising edge
    int   midx  = 0;
    logic dprev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || sd_rdy) midx = 0;
        else if (sd_clk && !dprev) midx++;
        sd_di = (midx < 8) ? pat[7-midx] : 1'b1;
        dprev = sd_clk;
    end

    // Monitor: rebuild each transfer and compare against the scoreboard
    logic       m_busy = 1'b0, p_sck = 1'b0, p_rdy = 1'b1;
    int         m_len, m_rises, m_first_hi, m_hi_run;
    logic       m_hi_bad;
    logic [7:0] m_mosi;
    exp_t       e;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            p_sck  = 1'b0;
            p_rdy  = 1'b1;
        end else begin
            if (p_rdy && !sd_rdy) begin
                m_busy = 1'b1; m_len = 0; m_rises = 0; m_mosi = 8'h00;
                m_first_hi = -1; m_hi_run = 0; m_hi_bad = 1'b0;
            end
            if (!sd_rdy) m_len++;
            if (!sd_clk && p_sck) begin
                if (m_first_hi < 0) m_first_hi = m_hi_run;
                else if (m_hi_run != m_first_hi) m_hi_bad = 1'b1;
                m_hi_run = 0;
            end
            if (sd_clk && !p_sck) begin
                m_rises++;
                m_mosi = {m_mosi[6:0], sd_do};
            end
            if (sd_clk) m_hi_run++;
            if (!p_rdy && sd_rdy && m_busy) begin
                m_busy = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_xfer: got rx %0h expected no transfer", sd_recvdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("recvdata", sd_recvdata, e.rx);
                    chk("mosi_byte", m_mosi, e.tx);
                    chk("busy_len", m_len, e.len);
                    chk("sck_rises", m_rises, 8);
                    chk("sck_half", m_hi_bad ? -1 : m_first_hi, e.half);
                    chk("idle_sck_do", {sd_clk, sd_do}, 2'b01);
                end
            end
            p_sck = sd_clk;
            p_rdy = sd_rdy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [1:0] rs, input logic [7:0] d);
        module_select = 1'b1; write_strobe = 1'b1; regsel = rs; din = d;
        tick();
        module_select = 1'b0; write_strobe = 1'b0;
    endtask

    task automatic push(input logic [7:0] rx, input logic [7:0] tx, input int len,
                        input int half);
        exp_t x;
        x.rx = rx; x.tx = tx; x.len = len; x.half = half;
        exp_q.push_back(x);
    endtask

    task automatic start_ff(input logic [7:0] miso, input int len, input int half);
        pat = miso;
        push(miso, 8'hFF, len, half);
        sd_start = 1'b1;
        tick();
        sd_start = 1'b0;
        chk("rdy_low_after_start", sd_rdy, 0);
    endtask

    task automatic start_cpu(input logic [7:0] d, input logic [7:0] miso, input int len,
                             input int half);
        pat = miso;
        push(miso, d, len, half);
        cpu_wr(2'b00, d);
        chk("rdy_low_after_cpu_start", sd_rdy, 0);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (sd_rdy) done = 1'b1;
            else tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout: got rdy %0b expected 1 within %0d", sd_rdy, budget);
        end
    endtask

    initial begin
        rst_n = 1'b0; sd_start = 1'b0; din = 8'h00; module_select = 1'b0;
        write_strobe = 1'b0; regsel = 2'b01; sd_di = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_rdy", sd_rdy, 1);
        chk("rst_recv", sd_recvdata, 8'hFF);
        chk("rst_pins", {sd_clk, sd_do, sd_cs_n}, 3'b011);
        chk("rst_ctrl_rd", dout, 8'h03);
        regsel = 2'b11;
        #1 chk("reserved_rd", dout, 8'hFF);

        // Fast mode, DMA start, MISO A5
        cpu_wr(2'b01, 8'h00);
        chk("cs_low", sd_cs_n, 0);
        start_ff(8'hA5, 16, 1);
        wait_idle(40);
        regsel = 2'b00;
        #1 chk("data_rd", dout, 8'hA5);

        // Back-to-back CPU write 40, MISO all ones, status while busy
        start_cpu(8'h40, 8'hFF, 16, 1);
        regsel = 2'b10;
        #1 chk("status_busy", dout, 8'h80);
        wait_idle(40);
        regsel = 2'b10;
        #1 chk("status_idle", dout, 8'h00);

        // Simultaneous DMA start and CPU data write: DMA wins
        pat = 8'h3C;
        push(8'h3C, 8'hFF, 16, 1);
        sd_start = 1'b1;
        cpu_wr(2'b00, 8'h00);
        sd_start = 1'b0;
        repeat (5) tick();
        // Requests while busy must be dropped
        sd_start = 1'b1;
        cpu_wr(2'b00, 8'h12);
        sd_start = 1'b0;
        wait_idle(40);
        repeat (20) tick();
        chk("no_queued_start", sd_rdy, 1);
        chk("queue_after_ignored", exp_q.size(), 0);

        // cs_n write mid-transfer applies next edge
        start_ff(8'h81, 16, 1);
        repeat (3) tick();
        cpu_wr(2'b01, 8'h01);
        chk("cs_mid_xfer", sd_cs_n, 1);
        regsel = 2'b01;
        #1 chk("ctrl_rd_01", dout, 8'h01);
        wait_idle(40);

        // Slow-mode write mid-transfer affects only the next byte
        start_ff(8'h7E, 16, 1);
        repeat (3) tick();
        cpu_wr(2'b01, 8'h02);
        chk("cs_low_again", sd_cs_n, 0);
        wait_idle(40);
        start_ff(8'hC3, 960, 60);
        wait_idle(1100);

        // Reset at bit 4 of a fast transfer
        cpu_wr(2'b01, 8'h00);
        start_ff(8'h5A, 16, 1);
        repeat (8) tick();
        regsel = 2'b01;
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", sd_rdy, 1);
        chk("arst_recv", sd_recvdata, 8'hFF);
        chk("arst_pins", {sd_clk, sd_do, sd_cs_n}, 3'b011);
        chk("arst_ctrl", dout, 8'h03);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Slow default after reset
        start_ff(8'h96, 960, 60);
        wait_idle(1100);

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
